// File: rtl/rsa_exp_ctrl_pkg.sv
// Package rsa_ctrl_pkg: shared sizes, command-select codes and controller
// state encoding for the rsa_exp_ctrl block.
//   OPERAND_W : width of every montgomery_exp operand/result (1024)
//   WORD_W    : command/result stream word width (32)
//   N_WORDS   : words per operand (32)
package rsa_ctrl_pkg;

  localparam int unsigned OPERAND_W = 1024;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned N_WORDS   = OPERAND_W / WORD_W;
  localparam int unsigned BEAT_W    = $clog2(N_WORDS);

  typedef logic [2:0] cmd_sel_t;

  localparam cmd_sel_t SEL_MSG    = 3'd0;
  localparam cmd_sel_t SEL_EXP    = 3'd1;
  localparam cmd_sel_t SEL_N      = 3'd2;
  localparam cmd_sel_t SEL_RMODN  = 3'd3;
  localparam cmd_sel_t SEL_R2MODN = 3'd4;
  localparam cmd_sel_t SEL_GO_ENC = 3'd5;
  localparam cmd_sel_t SEL_GO_DEC = 3'd6;
  localparam cmd_sel_t SEL_RSVD   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/rsa_exp_ctrl_if.sv
// Command / result stream bundle for rsa_exp_ctrl.
//   cmd_valid/cmd_ready/cmd_sel/cmd_data : operand-load and go commands
//   res_valid/res_ready/res_data/res_last: 32-word result stream
// master = host side, slave = controller side.
interface rsa_exp_ctrl_if;
  import rsa_ctrl_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  cmd_sel_t          cmd_sel;
  logic [WORD_W-1:0] cmd_data;
  logic              res_valid;
  logic              res_ready;
  logic [WORD_W-1:0] res_data;
  logic              res_last;

  modport master (
    output cmd_valid, cmd_sel, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_last
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_last
  );

endinterface

// File: rtl/rsa_result_serializer.sv
// rsa_result_serializer: loads a 1024-bit result and streams it out as
// 32 words, least-significant word first.
//   clk, resetn : clock, async active-low reset
//   i_load      : capture i_result and start streaming
//   i_result    : 1024-bit result from the core
//   i_ready     : downstream ready
//   o_valid     : word available
//   o_data      : current word
//   o_last      : current word is beat 31
//   o_done      : final beat handshakes this cycle
module rsa_result_serializer
  import rsa_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_load,
  input  logic [OPERAND_W-1:0] i_result,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [WORD_W-1:0]    o_data,
  output logic                 o_last,
  output logic                 o_done
);

  logic [OPERAND_W-1:0] r_shift;
  logic [BEAT_W-1:0]    r_beat;
  logic                 r_valid;
  logic                 w_fire;

  assign w_fire  = r_valid && i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_shift[WORD_W-1:0];
  assign o_last  = r_valid && (r_beat == BEAT_W'(N_WORDS - 1));
  assign o_done  = w_fire && o_last;

  // Data and last only move on a handshake, so they hold during stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_result;
      r_beat  <= '0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      r_shift <= r_shift >> WORD_W;
      r_beat  <= r_beat + 1'b1;
      if (o_last) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: command front-end for a montgomery_exp core. Shifts 32-bit
// operand words into 1024-bit registers, issues a one-cycle core_start on a
// go command, waits for core_done, then streams the result as 32 words.
//   clk, resetn       : clock, async active-low reset
//   bus (slave)       : command and result stream handshakes
//   busy              : state is not IDLE
//   timeout_err       : sticky core-timeout flag
//   core_*            : operands/control to the core, result/done back
// Optional feature: define RSA_CTRL_TIMEOUT_EN to abandon WAIT after
// TIMEOUT_CYCLES cycles without core_done.
module rsa_exp_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                 clk,
  input  logic                 resetn,
  rsa_exp_ctrl_if.slave        bus,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 core_start,
  output logic                 core_encryp_mode,
  output logic [OPERAND_W-1:0] core_msg,
  output logic [OPERAND_W-1:0] core_exp,
  output logic [OPERAND_W-1:0] core_n,
  output logic [OPERAND_W-1:0] core_rmodn,
  output logic [OPERAND_W-1:0] core_r2modn,
  input  logic [OPERAND_W-1:0] core_result,
  input  logic                 core_done
);

  state_t               r_state;
  state_t               w_next;
  logic                 w_fire;
  logic                 w_go;
  logic                 w_load;
  logic                 w_ser_done;
  logic [OPERAND_W-1:0] r_msg, r_exp, r_n, r_rmodn, r_r2modn;
  logic                 r_encryp;

  assign w_fire = bus.cmd_valid && (r_state == ST_IDLE);
  assign w_go   = w_fire && ((bus.cmd_sel == SEL_GO_ENC) || (bus.cmd_sel == SEL_GO_DEC));

  assign bus.cmd_ready    = (r_state == ST_IDLE);
  assign busy             = (r_state != ST_IDLE);
  assign core_start       = (r_state == ST_START);
  assign core_encryp_mode = r_encryp;
  assign core_msg         = r_msg;
  assign core_exp         = r_exp;
  assign core_n           = r_n;
  assign core_rmodn       = r_rmodn;
  assign core_r2modn      = r_r2modn;

`ifdef RSA_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;
  logic            w_timeout;

  assign timeout_err = r_timeout_err;

  // Counter is cleared outside WAIT, so it holds the number of WAIT cycles
  // already elapsed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != ST_WAIT) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_go) begin
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
`ifdef RSA_CTRL_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_next = ST_START;
        end
      end
      ST_START: begin
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          w_next = ST_DRAIN;
          w_load = 1'b1;
        end
`ifdef RSA_CTRL_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
`endif
      end
      ST_DRAIN: begin
        if (w_ser_done) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Operand words enter at the top so the first of 32 writes ends at [31:0].
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_msg    <= '0;
      r_exp    <= '0;
      r_n      <= '0;
      r_rmodn  <= '0;
      r_r2modn <= '0;
      r_encryp <= 1'b0;
    end else if (w_fire) begin
      unique case (bus.cmd_sel)
        SEL_MSG:    r_msg    <= {bus.cmd_data, r_msg[OPERAND_W-1:WORD_W]};
        SEL_EXP:    r_exp    <= {bus.cmd_data, r_exp[OPERAND_W-1:WORD_W]};
        SEL_N:      r_n      <= {bus.cmd_data, r_n[OPERAND_W-1:WORD_W]};
        SEL_RMODN:  r_rmodn  <= {bus.cmd_data, r_rmodn[OPERAND_W-1:WORD_W]};
        SEL_R2MODN: r_r2modn <= {bus.cmd_data, r_r2modn[OPERAND_W-1:WORD_W]};
        SEL_GO_ENC: r_encryp <= 1'b1;
        SEL_GO_DEC: r_encryp <= 1'b0;
        SEL_RSVD:   ;
        default:    ;
      endcase
    end
  end

  rsa_result_serializer u_ser (
    .clk      (clk),
    .resetn   (resetn),
    .i_load   (w_load),
    .i_result (core_result),
    .i_ready  (bus.res_ready),
    .o_valid  (bus.res_valid),
    .o_data   (bus.res_data),
    .o_last   (bus.res_last),
    .o_done   (w_ser_done)
  );

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
module tb_rsa_exp_ctrl;
  import rsa_ctrl_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rsa_exp_ctrl_if bus();

  logic        busy, timeout_err, core_start, core_encryp_mode, core_done;
  logic [1023:0] core_msg, core_exp, core_n, core_rmodn, core_r2modn, core_result;

  rsa_exp_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .bus              (bus),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .core_start       (core_start),
    .core_encryp_mode (core_encryp_mode),
    .core_msg         (core_msg),
    .core_exp         (core_exp),
    .core_n           (core_n),
    .core_rmodn       (core_rmodn),
    .core_r2modn      (core_r2modn),
    .core_result      (core_result),
    .core_done        (core_done)
  );

  // Behavioural core: done rises core_lat cycles after start and then stays
  // high until the next start; result is garbage until done.
  int unsigned   core_lat = 100;
  int unsigned   core_cnt;
  bit            core_active;
  logic          core_done_r;
  logic [1023:0] model_res;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_active <= 1'b0;
      core_done_r <= 1'b0;
      core_cnt    <= 0;
    end else if (core_start) begin
      core_done_r <= 1'b0;
      core_active <= (core_lat != 0);
      core_cnt    <= 1;
    end else if (core_active) begin
      if (core_cnt >= core_lat) begin
        core_done_r <= 1'b1;
        core_active <= 1'b0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  assign core_done   = core_done_r;
  assign core_result = core_done_r ? model_res : ~model_res;

  int start_cnt = 0;
  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference operand registers: a window of the last 32 words written per
  // select, oldest word is the least significant.
  logic [31:0] ref_q [5][$];

  function automatic void ref_clear();
    for (int s = 0; s < 5; s++) begin
      ref_q[s].delete();
      for (int j = 0; j < 32; j++) ref_q[s].push_back(32'h0);
    end
  endfunction

  function automatic logic [1023:0] ref_val(input int s);
    logic [1023:0] v;
    for (int j = 0; j < 32; j++) v[32*j +: 32] = ref_q[s][j];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int idx = -1;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      for (int i = 0; i < 32; i++)
        if (idx < 0 && obs[32*i +: 32] !== exp[32*i +: 32]) idx = i;
      if (idx < 0) idx = 0;
      $error("FAIL %s: word %0d observed %h expected %h", tag, idx,
             obs[32*idx +: 32], exp[32*idx +: 32]);
    end
  endtask

  task automatic chk_ops(input string tag);
    chk_wide({tag, "_msg"},    core_msg,    ref_val(0));
    chk_wide({tag, "_exp"},    core_exp,    ref_val(1));
    chk_wide({tag, "_n"},      core_n,      ref_val(2));
    chk_wide({tag, "_rmodn"},  core_rmodn,  ref_val(3));
    chk_wide({tag, "_r2modn"}, core_r2modn, ref_val(4));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at #1 after the edge that transferred the command.
  task automatic send(input logic [2:0] sel, input logic [31:0] data);
    int g = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_data  = data;
    while (bus.cmd_ready !== 1'b1 && g < 1000) begin
      tick();
      g++;
    end
    if (g >= 1000) chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    if (sel < 3'd5) begin
      ref_q[sel].push_back(data);
      void'(ref_q[sel].pop_front());
    end
  endtask

  // mode 0: always ready, 1: ready toggles 1/0, 2: random ready.
  task automatic drain(input int mode, input logic [1023:0] exp_res, input string tag);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 0;
    logic [31:0] held_d;
    logic        held_l;
    logic        rdy;
    while (got < 32 && cyc < 3000) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      bus.res_ready = rdy;
      if (stalled) begin
        chk({tag, "_stall_data"}, bus.res_data, held_d);
        chk({tag, "_stall_last"}, 32'(bus.res_last), 32'(held_l));
        stalled = 0;
      end
      if (bus.res_valid === 1'b1) begin
        if (rdy) begin
          chk({tag, "_word"}, bus.res_data, exp_res[32*got +: 32]);
          chk({tag, "_last"}, 32'(bus.res_last), 32'(got == 31));
          got++;
        end else begin
          held_d  = bus.res_data;
          held_l  = bus.res_last;
          stalled = 1;
        end
      end
      tick();
      cyc++;
    end
    chk({tag, "_count"}, 32'(got), 32'd32);
    bus.res_ready = 1'b1;
    chk({tag, "_valid_after"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    repeat (3) begin
      tick();
      chk({tag, "_no_extra"}, 32'(bus.res_valid), 32'd0);
    end
    bus.res_ready = 1'b0;
  endtask

  task automatic rand_result();
    for (int k = 0; k < 32; k++) model_res[32*k +: 32] = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          b;
    bit          saw_valid;
    logic [31:0] exp_hi;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 3'd0;
    bus.cmd_data  = 32'h0;
    bus.res_ready = 1'b0;
    model_res     = '0;
    ref_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_last", 32'(bus.res_last), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_encryp", 32'(core_encryp_mode), 32'd0);
    chk_ops("rst");

    // 32 sequential msg words: first lands at the bottom
    for (int i = 0; i < 32; i++) send(3'd0, 32'(i));
    exp_hi = 32'h1F;
    chk("msg_low_word", core_msg[31:0], 32'h0);
    chk("msg_high_word", core_msg[1023:992], exp_hi);
    chk_ops("msg_seq");

    // Random operands, reserved command in between, partial extra writes
    for (int s = 1; s < 5; s++) begin
      for (int i = 0; i < 32; i++) begin
        send(3'(s), $urandom);
        if (i == 10) send(3'd7, $urandom);
      end
    end
    for (int i = 0; i < 5; i++) send(3'd1, $urandom);
    send(3'd7, $urandom);
    chk("sel7_idle", 32'(busy), 32'd0);
    chk_ops("rand_ops");

    // Decrypt run, fixed result pattern
    for (int k = 0; k < 32; k++) model_res[32*k +: 32] = 32'hA5000000 + 32'(k);
    core_lat  = 100;
    start_cnt = 0;
    send(3'd6, $urandom);
    chk("dec_start_T1", 32'(core_start), 32'd1);
    chk("dec_busy", 32'(busy), 32'd1);
    chk("dec_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    chk("dec_start_T2", 32'(core_start), 32'd0);
    chk("dec_mode", 32'(core_encryp_mode), 32'd0);
    drain(0, model_res, "dec");
    chk("dec_start_pulses", 32'(start_cnt), 32'd1);
    chk_ops("dec_hold");

    // Encrypt run, ready toggling; core_done still high from previous run
    rand_result();
    core_lat = $urandom_range(3, 40);
    send(3'd5, $urandom);
    chk("enc_mode", 32'(core_encryp_mode), 32'd1);
    drain(1, model_res, "enc_tog");

    // Random backpressure
    rand_result();
    core_lat = $urandom_range(1, 30);
    send(3'd6, $urandom);
    chk("rnd_timeout_clr", 32'(timeout_err), 32'd0);
    drain(2, model_res, "rnd");

    // Asynchronous reset in WAIT
    core_lat = 100;
    send(3'd5, $urandom);
    repeat (10) tick();
    chk("wait_busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rstw_core_start", 32'(core_start), 32'd0);
    chk("rstw_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rstw_encryp", 32'(core_encryp_mode), 32'd0);
    ref_clear();
    chk_ops("rstw");
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 3; i++) send(3'd2, $urandom);
    rand_result();
    core_lat = 25;
    send(3'd6, $urandom);
    drain(0, model_res, "post_rstw");
    chk_ops("post_rstw");

    // Asynchronous reset in DRAIN
    rand_result();
    core_lat = 5;
    bus.res_ready = 1'b0;
    send(3'd6, $urandom);
    b = 0;
    while (bus.res_valid !== 1'b1 && b < 200) begin
      tick();
      b++;
    end
    chk("drain_reached", 32'(bus.res_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rstd_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rstd_res_last", 32'(bus.res_last), 32'd0);
    chk("rstd_busy", 32'(busy), 32'd0);
    ref_clear();
    @(posedge clk);
    #1 resetn = 1'b1;
    rand_result();
    core_lat = 12;
    send(3'd5, $urandom);
    drain(2, model_res, "post_rstd");

`ifdef RSA_CTRL_TIMEOUT_EN
    // Core never completes: START + 16 WAIT cycles, then IDLE with error
    core_lat  = 0;
    saw_valid = 0;
    send(3'd6, $urandom);
    b = 0;
    while (busy === 1'b1 && b < 100) begin
      if (bus.res_valid === 1'b1) saw_valid = 1;
      tick();
      b++;
    end
    chk("to_busy_cycles", 32'(b), 32'd17);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("to_no_valid", 32'(saw_valid), 32'd0);
    rand_result();
    core_lat = 8;
    send(3'd5, $urandom);
    chk("to_err_cleared", 32'(timeout_err), 32'd0);
    drain(0, model_res, "post_to");
`else
    // Without the timeout feature WAIT persists
    core_lat = 0;
    send(3'd6, $urandom);
    repeat (200) tick();
    chk("nto_busy", 32'(busy), 32'd1);
    chk("nto_err", 32'(timeout_err), 32'd0);
    chk("nto_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    resetn = 1'b0;
    #1;
    chk("nto_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
